seq_scan_sched: RTL and testbench

Round-robin scheduler that shares one serial `1011` sequence detector among `NREQ` requesters. Each requester submits a `WORD_W`-bit word. The block grants one requester at a time, clears the detector, and shifts the word into it MSB first. It counts the detector's `seq_seen` pulses and returns a per-word result (hit count and first hit position) on a valid/ready response port. It sits between the word-level producers and the bit-serial detector instance. The detector instance is external, so its reset, input and output are ports of this block.

---
 rtl/seq_scan_sched.sv | 189 ++++++++++++++++++
 tb/tb_seq_scan_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_sched.sv
// seq_scan_sched
// ---------------
// Shares one external bit-serial "1011" detector among NREQ word-level
// requesters. A round-robin arbiter picks one requester, the detector is
// cleared for one cycle, the word is shifted in MSB first, the detector's
// seq_seen pulses are counted, and a per-word result is returned.
//
// Handshakes: a transfer happens on any rising clk edge where valid and
// ready are both high. A source holds its payload stable from raising
// valid until that edge. req_ready is a one-hot grant that does not depend
// on req_valid of the granted requester being sampled twice. rsp_* stays
// stable while rsp_valid is high and rsp_ready is low.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   req_valid/req_data    per-requester request, word k at [k*WORD_W +: WORD_W]
//   req_ready             one-hot grant (combinational, IDLE only)
//   det_reset             synchronous clear to the detector (high in CLR / reset)
//   det_inp_bit           serial bit to the detector
//   det_seq_seen          detector output
//   rsp_valid/rsp_ready   result handshake
//   rsp_id                index of the served requester
//   rsp_hits              number of detector pulses for the word
//   rsp_first_pos         index (0 = MSB) of the bit completing the first hit
//   dbg_state             current FSM state, for observation
module seq_scan_sched #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WORD_W-1:0]    req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      det_reset,
    output logic                      det_inp_bit,
    input  logic                      det_seq_seen,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [$clog2(WORD_W):0]   rsp_hits,
    output logic [$clog2(WORD_W)-1:0] rsp_first_pos,
    output logic [2:0]                dbg_state
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int POS_W = $clog2(WORD_W);
    localparam int HIT_W = POS_W + 1;
    localparam logic [POS_W-1:0] LAST_BIT = POS_W'(WORD_W - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NREQ - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_found;
    logic              take;
    logic [WORD_W-1:0] grant_word;
    logic [WORD_W-1:0] shreg;
    logic [POS_W-1:0]  bit_cnt;
    logic              hit_sample;
    logic [POS_W-1:0]  hit_pos;

    assign dbg_state  = state_q;
    assign grant_word = req_data[int'(grant_idx)*WORD_W +: WORD_W];

    // Round-robin search. Offsets are walked from the far end back to the
    // pointer so the last match written is the one closest to the pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int o = NREQ - 1; o >= 0; o--) begin
            cand = ID_W'((int'(rr_ptr) + o) % NREQ);
            if (req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next state, grant and hit sampling.
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        take       = 1'b0;
        hit_sample = 1'b0;
        hit_pos    = '0;
        case (state_q)
            IDLE: begin
                // Gated by reset so no grant is shown while reset is held.
                if (grant_found && reset) begin
                    req_ready[grant_idx] = 1'b1;
                    take                 = 1'b1;
                    state_d              = CLR;
                end
            end
            CLR:   state_d = SHIFT;
            SHIFT: begin
                // seq_seen seen in shift cycle i reports bit i-1.
                if (bit_cnt != '0 && det_seq_seen) begin
                    hit_sample = 1'b1;
                    hit_pos    = bit_cnt - POS_W'(1);
                end
                if (bit_cnt == LAST_BIT) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (det_seq_seen) begin
                    hit_sample = 1'b1;
                    hit_pos    = LAST_BIT;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath. det_reset / rsp_valid / det_inp_bit are registered from the
    // next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr        <= '0;
            shreg         <= '0;
            bit_cnt       <= '0;
            rsp_id        <= '0;
            rsp_hits      <= '0;
            rsp_first_pos <= '0;
            rsp_valid     <= 1'b0;
            det_reset     <= 1'b1;
            det_inp_bit   <= 1'b0;
        end else begin
            det_reset   <= (state_d == CLR);
            rsp_valid   <= (state_d == RESP);
            det_inp_bit <= 1'b0;

            if (take) begin
                shreg         <= grant_word;
                rsp_id        <= grant_idx;
                rsp_hits      <= '0;
                rsp_first_pos <= '0;
                rr_ptr        <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
            end

            // The first bit is staged during CLR so it is on the wire for
            // shift cycle 0; each shift cycle stages the following bit.
            if (state_q == CLR) begin
                bit_cnt     <= '0;
                det_inp_bit <= shreg[WORD_W-1];
                shreg       <= shreg << 1;
            end

            if (state_q == SHIFT && bit_cnt != LAST_BIT) begin
                det_inp_bit <= shreg[WORD_W-1];
                shreg       <= shreg << 1;
                bit_cnt     <= bit_cnt + POS_W'(1);
            end

            if (hit_sample) begin
                rsp_hits <= rsp_hits + HIT_W'(1);
                if (rsp_hits == '0) begin
                    rsp_first_pos <= hit_pos;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_scan_sched.sv
// Bench for seq_scan_sched (NREQ=4, WORD_W=16). Contains a behavioural
// model of the external non-overlapping "1011" detector, a monitor that
// logs transfers/responses, and a word-level reference scan.
module tb_seq_scan_sched;
    localparam int TR_N = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        det_reset;
    logic        det_inp_bit;
    logic        det_seq_seen;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [4:0]  rsp_hits;
    logic [3:0]  rsp_first_pos;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    seq_scan_sched #(.NREQ(4), .WORD_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .det_reset(det_reset), .det_inp_bit(det_inp_bit),
        .det_seq_seen(det_seq_seen), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_hits(rsp_hits), .rsp_first_pos(rsp_first_pos),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- external detector model ----------------
    // Remembers bits since its last restart; a 1011 ending on the current
    // bit raises seen for one cycle, and the bit offered during that cycle
    // is thrown away before matching restarts.
    logic       d_seen = 1'b0;
    logic [2:0] d_hist = 3'b0;
    int         d_len  = 0;
    assign det_seq_seen = d_seen;

    always @(posedge clk) begin
        if (det_reset) begin
            d_seen <= 1'b0; d_hist <= 3'b0; d_len <= 0;
        end else if (d_seen) begin
            d_seen <= 1'b0; d_len <= 0;
        end else begin
            d_hist <= {d_hist[1:0], det_inp_bit};
            if (d_len >= 3 && {d_hist, det_inp_bit} == 4'b1011) begin
                d_seen <= 1'b1; d_len <= 0;
            end else begin
                d_len <= (d_len < 4) ? d_len + 1 : 4;
            end
        end
    end

    // ---------------- reference model ----------------
    // Word-level scan: hit when the last four bits since the restart point
    // read 1011; the following bit is skipped and matching restarts after it.
    function automatic void ref_scan(input logic [15:0] w, output int hits, output int pos);
        int start, i;
        hits = 0; pos = 0; start = 0; i = 0;
        while (i < 16) begin
            if (i - start >= 3 && w[15-(i-3)] && !w[15-(i-2)] && w[15-(i-1)] && w[15-i]) begin
                if (hits == 0) pos = i;
                hits++;
                start = i + 2;
                i = i + 2;
            end else begin
                i++;
            end
        end
    endfunction

    function automatic logic [15:0] pack(input int id, input int h, input int p);
        return 16'(id * 512 + h * 16 + p);
    endfunction

    // ---------------- monitor / scoreboard queues ----------------
    int          cyc = 0;
    bit          tr_rst [TR_N];
    bit          tr_bit [TR_N];
    int          xfer_id[$];
    int          xfer_cyc[$];
    int          rise_q[$];
    int          hs_cyc[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic        rsp_valid_prev = 1'b0;
    int          mon_h, mon_p;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < TR_N) begin
            tr_rst[cyc] = det_reset;
            tr_bit[cyc] = det_inp_bit;
        end
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    xfer_id.push_back(k);
                    xfer_cyc.push_back(cyc);
                    ref_scan(req_data[k*16 +: 16], mon_h, mon_p);
                    exp_q.push_back(pack(k, mon_h, mon_p));
                end
            end
            if (rsp_valid && !rsp_valid_prev) rise_q.push_back(cyc - 1);
            if (rsp_valid && rsp_ready) begin
                got_q.push_back(pack(int'(rsp_id), int'(rsp_hits), int'(rsp_first_pos)));
                hs_cyc.push_back(cyc);
            end
        end
        rsp_valid_prev = rsp_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        step();
        xfer_id.delete(); xfer_cyc.delete(); rise_q.delete(); hs_cyc.delete();
        exp_q.delete(); got_q.delete();
    endtask

    task automatic wait_drain();
        int t = 0;
        while (got_q.size() < xfer_id.size() && t < 300) begin step(); t++; end
    endtask

    task automatic issue(input int id, input logic [15:0] w, input int bp, output bit ok);
        int nx, nr;
        nx = xfer_id.size(); nr = got_q.size(); ok = 1'b0;
        req_data[id*16 +: 16] = w;
        req_valid[id] = 1'b1;
        rsp_ready = (bp == 0);
        for (int k = 0; k < 80 && xfer_id.size() == nx; k++) step();
        req_valid[id] = 1'b0;
        if (xfer_id.size() == nx) return;
        for (int k = 0; k < 80 && !rsp_valid; k++) step();
        repeat (bp) step();
        rsp_ready = 1'b1;
        for (int k = 0; k < 80 && got_q.size() == nr; k++) step();
        ok = (got_q.size() > nr);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1;
        req_data = {$urandom, $urandom};
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %0h expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (rsp_hits !== 5'd0) begin errors++; $display("FAIL reset_rsp_hits: got %0d expected 0", rsp_hits); end
        checks++; if (rsp_first_pos !== 4'd0) begin errors++; $display("FAIL reset_first_pos: got %0d expected 0", rsp_first_pos); end
        checks++; if (det_inp_bit !== 1'b0) begin errors++; $display("FAIL reset_det_inp_bit: got %0b expected 0", det_inp_bit); end
        checks++; if (det_reset !== 1'b1) begin errors++; $display("FAIL reset_det_reset: got %0b expected 1", det_reset); end
    endtask

    task automatic test_single_word();
        bit ok;
        int x, pulses;
        logic [15:0] bits_obs, bits_exp;
        logic [15:0] g;
        do_reset();
        issue(2, 16'hB580, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no response expected one"); end
        if (got_q.size() > 0 && rise_q.size() > 0 && xfer_cyc.size() > 0) begin
            g = got_q[0];
            checks++; if (int'(g >> 9) != 2) begin errors++; $display("FAIL single_id: got %0d expected 2", g >> 9); end
            checks++; if (int'((g >> 4) & 31) != 2) begin errors++; $display("FAIL single_hits: got %0d expected 2", (g >> 4) & 31); end
            checks++; if (int'(g & 15) != 3) begin errors++; $display("FAIL single_first_pos: got %0d expected 3", g & 15); end
            checks++; if (rise_q[0] - xfer_cyc[0] != 18) begin errors++; $display("FAIL single_latency: got %0d expected 18", rise_q[0] - xfer_cyc[0]); end
            x = xfer_cyc[0];
            if (x + 20 < TR_N) begin
                pulses = 0;
                for (int k = x; k <= x + 19; k++) pulses += int'(tr_rst[k]);
                checks++; if (pulses != 1) begin errors++; $display("FAIL serial_det_reset_cycles: got %0d expected 1", pulses); end
                checks++; if (tr_rst[x+1] !== 1'b1) begin errors++; $display("FAIL serial_det_reset_pos: got %0b expected 1", tr_rst[x+1]); end
                bits_exp = 16'b1011010110000000;
                for (int k = 0; k < 16; k++) bits_obs[15-k] = tr_bit[x+2+k];
                checks++; if (bits_obs !== bits_exp) begin errors++; $display("FAIL serial_bits: got %04h expected %04h", bits_obs, bits_exp); end
                checks++; if (tr_bit[x+18] !== 1'b0 || tr_bit[x+1] !== 1'b0) begin errors++; $display("FAIL serial_idle_bit: got %0b%0b expected 00", tr_bit[x+1], tr_bit[x+18]); end
            end
        end
    endtask

    task automatic test_nonoverlap();
        logic [15:0] words [3];
        int eh [3];
        int ep [3];
        logic [15:0] g;
        bit ok;
        words = '{16'hBB00, 16'h5800, 16'hFFFF};
        eh = '{1, 1, 0};
        ep = '{3, 4, 0};
        for (int k = 0; k < 3; k++) begin
            issue(k, words[k], 0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL nonoverlap_timeout[%0d]: got no response expected one", k); end
            if (got_q.size() > 0) begin
                g = got_q[$];
                checks++; if (int'((g >> 4) & 31) != eh[k]) begin errors++; $display("FAIL nonoverlap_hits[%04h]: got %0d expected %0d", words[k], (g >> 4) & 31, eh[k]); end
                checks++; if (int'(g & 15) != ep[k]) begin errors++; $display("FAIL nonoverlap_pos[%04h]: got %0d expected %0d", words[k], g & 15, ep[k]); end
            end
        end
    endtask

    task automatic test_round_robin();
        int t;
        int order [5];
        bit ok;
        order = '{0, 1, 2, 3, 0};
        do_reset();
        for (int k = 0; k < 4; k++) req_data[k*16 +: 16] = 16'($urandom);
        rsp_ready = 1'b1; req_valid = 4'hF;
        t = 0;
        while (xfer_id.size() < 5 && t < 400) begin step(); t++; end
        req_valid = '0;
        wait_drain();
        checks++; if (xfer_id.size() != 5) begin errors++; $display("FAIL rr_grant_count: got %0d expected 5", xfer_id.size()); end
        for (int i = 0; i < 5 && i < xfer_id.size(); i++) begin
            checks++; if (xfer_id[i] != order[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, xfer_id[i], order[i]); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_result[%0d]: got %04h expected %04h", i, got_q[i], exp_q[i]); end
        end
        // Requester 1 served, then 1 and 3 both waiting: 3 first, then 1.
        do_reset();
        issue(1, 16'($urandom), 0, ok);
        req_data[16 +: 16] = 16'($urandom);
        req_data[48 +: 16] = 16'($urandom);
        req_valid = 4'b1010;
        t = 0;
        while (xfer_id.size() < 3 && t < 200) begin step(); t++; end
        req_valid = '0;
        wait_drain();
        checks++; if (xfer_id.size() != 3) begin errors++; $display("FAIL rr_variant_count: got %0d expected 3", xfer_id.size()); end
        if (xfer_id.size() >= 3) begin
            checks++; if (xfer_id[1] != 3) begin errors++; $display("FAIL rr_variant_first: got %0d expected 3", xfer_id[1]); end
            checks++; if (xfer_id[2] != 1) begin errors++; $display("FAIL rr_variant_second: got %0d expected 1", xfer_id[2]); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] w;
        int eh, ep, t, nx;
        do_reset();
        w = 16'hB580 ^ 16'($urandom_range(0, 255));
        ref_scan(w, eh, ep);
        req_data[32 +: 16] = w; req_valid[2] = 1'b1; rsp_ready = 1'b0;
        t = 0;
        while (xfer_id.size() == 0 && t < 50) begin step(); t++; end
        req_valid = '0;
        req_data[0 +: 16] = 16'($urandom); req_valid[0] = 1'b1;
        t = 0;
        while (!rsp_valid && t < 60) begin step(); t++; end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid: got %0b expected 1", rsp_valid); end
        for (int c = 0; c < 10; c++) begin
            checks++; if (pack(int'(rsp_id), int'(rsp_hits), int'(rsp_first_pos)) !== pack(2, eh, ep)) begin
                errors++; $display("FAIL bp_fields[%0d]: got %0d/%0d/%0d expected 2/%0d/%0d", c, rsp_id, rsp_hits, rsp_first_pos, eh, ep);
            end
            checks++; if ({rsp_valid, req_ready} !== 5'b10000) begin errors++; $display("FAIL bp_valid_ready[%0d]: got %05b expected 10000", c, {rsp_valid, req_ready}); end
            step();
        end
        rsp_ready = 1'b1;
        nx = xfer_id.size();
        t = 0;
        while (xfer_id.size() == nx && t < 10) begin step(); t++; end
        req_valid = '0;
        checks++; if (xfer_id.size() == nx || hs_cyc.size() == 0) begin
            errors++; $display("FAIL bp_next_grant: got none expected grant");
        end else if (xfer_cyc[$] - hs_cyc[$] != 1 || xfer_id[$] != 0) begin
            errors++; $display("FAIL bp_next_grant: got id %0d after %0d cycles expected id 0 after 1", xfer_id[$], xfer_cyc[$] - hs_cyc[$]);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int t;
        do_reset();
        req_data[16 +: 16] = 16'hB5AD; req_valid[1] = 1'b1; rsp_ready = 1'b1;
        t = 0;
        while (xfer_id.size() == 0 && t < 50) begin step(); t++; end
        req_valid = '0;
        repeat (8) step();
        for (int k = 0; k < 4; k++) req_data[k*16 +: 16] = 16'($urandom);
        req_valid = 4'hF;
        #3 reset = 1'b0;
        #1;
        checks++; if (det_reset !== 1'b1) begin errors++; $display("FAIL midrst_det_reset: got %0b expected 1", det_reset); end
        checks++; if (det_inp_bit !== 1'b0) begin errors++; $display("FAIL midrst_det_inp_bit: got %0b expected 0", det_inp_bit); end
        checks++; if (rsp_hits !== 5'd0) begin errors++; $display("FAIL midrst_rsp_hits: got %0d expected 0", rsp_hits); end
        checks++; if ({rsp_valid, req_ready} !== 5'b0) begin errors++; $display("FAIL midrst_valid_ready: got %05b expected 00000", {rsp_valid, req_ready}); end
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        t = 0;
        while (xfer_id.size() < 2 && t < 20) begin step(); t++; end
        req_valid = '0;
        checks++; if (xfer_id.size() != 2 || xfer_id[$] != 0) begin errors++; $display("FAIL midrst_first_grant: got %0d expected 0", xfer_id.size() > 0 ? xfer_id[$] : -1); end
        t = 0;
        while (got_q.size() < 1 && t < 60) begin step(); t++; end
        repeat (25) step();
        checks++; if (rise_q.size() != 1 || got_q.size() != 1) begin errors++; $display("FAIL midrst_responses: got %0d expected 1", rise_q.size()); end
        if (got_q.size() > 0 && exp_q.size() == 2) begin
            checks++; if (got_q[0] !== exp_q[1]) begin errors++; $display("FAIL midrst_result: got %04h expected %04h", got_q[0], exp_q[1]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] pats [6];
        logic [15:0] w, g, e;
        int id, bp, lat;
        bit ok;
        pats = '{16'hBBBB, 16'hB5AD, 16'h2D6B, 16'h0B0B, 16'hFFFF, 16'h000B};
        do_reset();
        for (int n = 0; n < 24; n++) begin
            id = $urandom_range(0, 3);
            w  = ($urandom_range(0, 3) == 0) ? pats[$urandom_range(0, 5)] : 16'($urandom);
            bp = $urandom_range(0, 3);
            issue(id, w, bp, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_timeout[%0d]: got no response expected one", n); end
            if (got_q.size() > 0 && exp_q.size() > 0 && rise_q.size() > 0 && xfer_cyc.size() > 0) begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                lat = rise_q.pop_front() - xfer_cyc.pop_front();
                void'(xfer_id.pop_front());
                checks++; if (g !== e) begin errors++; $display("FAIL rand_result[%0d] word %04h: got %04h expected %04h", n, w, g, e); end
                checks++; if (lat != 18) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 18", n, lat); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        test_reset();
        test_single_word();
        test_nonoverlap();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
